// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a single memory port.
// Keeps one transaction outstanding, registers the memory-side outputs and aborts when memory stalls.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic [AW-1:0] iM0Addr,
  input  logic [DW-1:0] iM0Data,
  input  logic          iM0Read,
  input  logic          iM0Write,
  output logic [DW-1:0] oM0Data,
  output logic          oM0Rdy,
  input  logic [AW-1:0] iM1Addr,
  input  logic [DW-1:0] iM1Data,
  input  logic          iM1Read,
  input  logic          iM1Write,
  output logic [DW-1:0] oM1Data,
  output logic          oM1Rdy,
  output logic          oErr,
  output logic [1:0]    oGnt,
  output logic [AW-1:0] oMemAddr,
  output logic [DW-1:0] oMemData,
  output logic          oMemRead,
  output logic          oMemWrite,
  input  logic [DW-1:0] iMemData,
  input  logic          iMemRdy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last_m1, last_m1_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      gnt_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic [DW-1:0]   mem_data_nxt;
  logic            mem_read_nxt;
  logic            mem_write_nxt;
  logic [DW-1:0]   m0_data_nxt;
  logic [DW-1:0]   m1_data_nxt;
  logic            m0_rdy_nxt;
  logic            m1_rdy_nxt;
  logic            err_nxt;

  logic req0;
  logic req1;
  logic pick1;
  logic sel_read;
  logic sel_write;

  assign req0 = iM0Read | iM0Write;
  assign req1 = iM1Read | iM1Write;
  // On a tie the master that was not served last wins.
  assign pick1     = req1 & (~req0 | ~last_m1);
  assign sel_read  = pick1 ? iM1Read  : iM0Read;
  assign sel_write = pick1 ? iM1Write : iM0Write;

  // Registered state and outputs
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      last_m1   <= 1'b1;
      cnt       <= '0;
      oGnt      <= 2'b00;
      oMemAddr  <= '0;
      oMemData  <= '0;
      oMemRead  <= 1'b0;
      oMemWrite <= 1'b0;
      oM0Data   <= '0;
      oM1Data   <= '0;
      oM0Rdy    <= 1'b0;
      oM1Rdy    <= 1'b0;
      oErr      <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_m1   <= last_m1_nxt;
      cnt       <= cnt_nxt;
      oGnt      <= gnt_nxt;
      oMemAddr  <= mem_addr_nxt;
      oMemData  <= mem_data_nxt;
      oMemRead  <= mem_read_nxt;
      oMemWrite <= mem_write_nxt;
      oM0Data   <= m0_data_nxt;
      oM1Data   <= m1_data_nxt;
      oM0Rdy    <= m0_rdy_nxt;
      oM1Rdy    <= m1_rdy_nxt;
      oErr      <= err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    last_m1_nxt   = last_m1;
    cnt_nxt       = cnt;
    gnt_nxt       = oGnt;
    mem_addr_nxt  = oMemAddr;
    mem_data_nxt  = oMemData;
    mem_read_nxt  = oMemRead;
    mem_write_nxt = oMemWrite;
    m0_data_nxt   = oM0Data;
    m1_data_nxt   = oM1Data;
    m0_rdy_nxt    = 1'b0;
    m1_rdy_nxt    = 1'b0;
    err_nxt       = 1'b0;

    unique case (state)
      IDLE: begin
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        if (req0 | req1) begin
          mem_addr_nxt  = pick1 ? iM1Addr : iM0Addr;
          mem_data_nxt  = pick1 ? iM1Data : iM0Data;
          mem_write_nxt = sel_write;
          mem_read_nxt  = sel_read & ~sel_write;
          gnt_nxt       = pick1 ? 2'b10 : 2'b01;
          last_m1_nxt   = pick1;
          cnt_nxt       = '0;
          state_nxt     = BUSY;
        end
      end

      BUSY: begin
        if (iMemRdy) begin
          if (oGnt[1]) m1_data_nxt = iMemData;
          else         m0_data_nxt = iMemData;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          m0_rdy_nxt    = oGnt[0];
          m1_rdy_nxt    = oGnt[1];
          state_nxt     = DONE;
        end else if (cnt == CNT_LAST) begin
          // Memory never answered: complete the transfer with an error and zero data.
          if (oGnt[1]) m1_data_nxt = '0;
          else         m0_data_nxt = '0;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          m0_rdy_nxt    = oGnt[0];
          m1_rdy_nxt    = oGnt[1];
          err_nxt       = 1'b1;
          state_nxt     = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DONE: begin
        gnt_nxt   = 2'b00;
        state_nxt = IDLE;
      end

      default: begin
        gnt_nxt       = 2'b00;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus timeout and reset sequences.
module tb_mem_bus_arbiter;

  logic        iClk;
  logic        iRst;
  logic [31:0] iM0Addr, iM0Data, iM1Addr, iM1Data, iMemData;
  logic        iM0Read, iM0Write, iM1Read, iM1Write, iMemRdy;
  logic [31:0] oM0Data, oM1Data, oMemAddr, oMemData;
  logic        oM0Rdy, oM1Rdy, oErr, oMemRead, oMemWrite;
  logic [1:0]  oGnt;

  int n_chk  = 0;
  int n_fail = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .iClk(iClk), .iRst(iRst),
    .iM0Addr(iM0Addr), .iM0Data(iM0Data), .iM0Read(iM0Read), .iM0Write(iM0Write),
    .oM0Data(oM0Data), .oM0Rdy(oM0Rdy),
    .iM1Addr(iM1Addr), .iM1Data(iM1Data), .iM1Read(iM1Read), .iM1Write(iM1Write),
    .oM1Data(oM1Data), .oM1Rdy(oM1Rdy),
    .oErr(oErr), .oGnt(oGnt),
    .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .iMemData(iMemData), .iMemRdy(iMemRdy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct packed {
    logic        m0r, m0w;
    logic [31:0] m0a, m0d;
    logic        m1r, m1w;
    logic [31:0] m1a, m1d;
    logic        mrdy;
    logic [31:0] mdat;
    logic [1:0]  gnt;
    logic        rd, wr;
    logic [31:0] maddr, mwdat;
    logic        rdy0, rdy1, err;
    logic [31:0] d0, d1;
  } vec_t;

  vec_t vt[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic m0r, input logic m0w, input logic [31:0] m0a, input logic [31:0] m0d,
                       input logic m1r, input logic m1w, input logic [31:0] m1a, input logic [31:0] m1d,
                       input logic mrdy, input logic [31:0] mdat);
    iM0Read = m0r; iM0Write = m0w; iM0Addr = m0a; iM0Data = m0d;
    iM1Read = m1r; iM1Write = m1w; iM1Addr = m1a; iM1Data = m1d;
    iMemRdy = mrdy; iMemData = mdat;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] gnt, input logic rd, input logic wr,
                            input logic [31:0] maddr, input logic [31:0] mwdat,
                            input logic rdy0, input logic rdy1, input logic err,
                            input logic [31:0] d0, input logic [31:0] d1);
    chk({tag, " oGnt"},      {30'd0, oGnt}, {30'd0, gnt});
    chk({tag, " oMemRead"},  {31'd0, oMemRead}, {31'd0, rd});
    chk({tag, " oMemWrite"}, {31'd0, oMemWrite}, {31'd0, wr});
    chk({tag, " oMemAddr"},  oMemAddr, maddr);
    chk({tag, " oMemData"},  oMemData, mwdat);
    chk({tag, " oM0Rdy"},    {31'd0, oM0Rdy}, {31'd0, rdy0});
    chk({tag, " oM1Rdy"},    {31'd0, oM1Rdy}, {31'd0, rdy1});
    chk({tag, " oErr"},      {31'd0, oErr}, {31'd0, err});
    chk({tag, " oM0Data"},   oM0Data, d0);
    chk({tag, " oM1Data"},   oM1Data, d1);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    // m0r m0w m0a m0d | m1r m1w m1a m1d | mrdy mdat || gnt rd wr maddr mwdat rdy0 rdy1 err d0 d1
    vt[0]  = '{1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         1'b1,32'h77,
               2'b00,1'b0,1'b0,32'h0,32'h0,          1'b0,1'b0,1'b0,32'h0,32'h0};
    vt[1]  = '{1'b0,1'b1,32'h10,32'hA5A5A5A5, 1'b0,1'b0,32'h0,32'h0,         1'b0,32'h0,
               2'b01,1'b0,1'b1,32'h10,32'hA5A5A5A5,  1'b0,1'b0,1'b0,32'h0,32'h0};
    vt[2]  = '{1'b0,1'b1,32'h10,32'hA5A5A5A5, 1'b0,1'b0,32'h0,32'h0,         1'b0,32'h0,
               2'b01,1'b0,1'b1,32'h10,32'hA5A5A5A5,  1'b0,1'b0,1'b0,32'h0,32'h0};
    vt[3]  = '{1'b0,1'b1,32'h10,32'hA5A5A5A5, 1'b0,1'b0,32'h0,32'h0,         1'b1,32'hDEADBEEF,
               2'b01,1'b0,1'b0,32'h10,32'hA5A5A5A5,  1'b1,1'b0,1'b0,32'hDEADBEEF,32'h0};
    vt[4]  = '{1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         1'b1,32'h99,
               2'b00,1'b0,1'b0,32'h10,32'hA5A5A5A5,  1'b0,1'b0,1'b0,32'hDEADBEEF,32'h0};
    vt[5]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'h20,32'hCAFE0000, 1'b0,32'h0,
               2'b10,1'b1,1'b0,32'h20,32'hCAFE0000,  1'b0,1'b0,1'b0,32'hDEADBEEF,32'h0};
    vt[6]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'h20,32'hCAFE0000, 1'b1,32'h12345678,
               2'b10,1'b0,1'b0,32'h20,32'hCAFE0000,  1'b0,1'b1,1'b0,32'hDEADBEEF,32'h12345678};
    vt[7]  = '{1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         1'b0,32'h0,
               2'b00,1'b0,1'b0,32'h20,32'hCAFE0000,  1'b0,1'b0,1'b0,32'hDEADBEEF,32'h12345678};
    vt[8]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b1,32'h30,32'h55,       1'b0,32'h0,
               2'b10,1'b0,1'b1,32'h30,32'h55,        1'b0,1'b0,1'b0,32'hDEADBEEF,32'h12345678};
    vt[9]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b1,32'h30,32'h55,       1'b1,32'h0BAD0000,
               2'b10,1'b0,1'b0,32'h30,32'h55,        1'b0,1'b1,1'b0,32'hDEADBEEF,32'h0BAD0000};
    vt[10] = '{1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         1'b0,32'h0,
               2'b00,1'b0,1'b0,32'h30,32'h55,        1'b0,1'b0,1'b0,32'hDEADBEEF,32'h0BAD0000};
    // continuous contention: M1 was served last, so M0, M1, M0, M1
    vt[11] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b0,32'h0,
               2'b01,1'b1,1'b0,32'h40,32'h0,         1'b0,1'b0,1'b0,32'hDEADBEEF,32'h0BAD0000};
    vt[12] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b1,32'h1111,
               2'b01,1'b0,1'b0,32'h40,32'h0,         1'b1,1'b0,1'b0,32'h1111,32'h0BAD0000};
    vt[13] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b0,32'h0,
               2'b00,1'b0,1'b0,32'h40,32'h0,         1'b0,1'b0,1'b0,32'h1111,32'h0BAD0000};
    vt[14] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b0,32'h0,
               2'b10,1'b0,1'b1,32'h50,32'h5050,      1'b0,1'b0,1'b0,32'h1111,32'h0BAD0000};
    vt[15] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b1,32'h2222,
               2'b10,1'b0,1'b0,32'h50,32'h5050,      1'b0,1'b1,1'b0,32'h1111,32'h2222};
    vt[16] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b0,32'h0,
               2'b00,1'b0,1'b0,32'h50,32'h5050,      1'b0,1'b0,1'b0,32'h1111,32'h2222};
    vt[17] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b0,32'h0,
               2'b01,1'b1,1'b0,32'h40,32'h0,         1'b0,1'b0,1'b0,32'h1111,32'h2222};
    vt[18] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b1,32'h3333,
               2'b01,1'b0,1'b0,32'h40,32'h0,         1'b1,1'b0,1'b0,32'h3333,32'h2222};
    vt[19] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b0,32'h0,
               2'b00,1'b0,1'b0,32'h40,32'h0,         1'b0,1'b0,1'b0,32'h3333,32'h2222};
    vt[20] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b0,32'h0,
               2'b10,1'b0,1'b1,32'h50,32'h5050,      1'b0,1'b0,1'b0,32'h3333,32'h2222};
    vt[21] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,32'h50,32'h5050,     1'b1,32'h4444,
               2'b10,1'b0,1'b0,32'h50,32'h5050,      1'b0,1'b1,1'b0,32'h3333,32'h4444};
    vt[22] = '{1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         1'b0,32'h0,
               2'b00,1'b0,1'b0,32'h50,32'h5050,      1'b0,1'b0,1'b0,32'h3333,32'h4444};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    iRst = 1'b1;
    #2;
    check_outs("reset_async", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check_outs("reset_held", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    iRst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(vt[i].m0r, vt[i].m0w, vt[i].m0a, vt[i].m0d,
            vt[i].m1r, vt[i].m1w, vt[i].m1a, vt[i].m1d, vt[i].mrdy, vt[i].mdat);
      tick();
      check_outs($sformatf("vec%0d", i), vt[i].gnt, vt[i].rd, vt[i].wr, vt[i].maddr, vt[i].mwdat,
                 vt[i].rdy0, vt[i].rdy1, vt[i].err, vt[i].d0, vt[i].d1);
    end

    // Timeout: M0 read, memory silent; abort on the 8th BUSY edge
    drive(1, 0, 32'h60, 32'h6, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("to_grant", 2'b01, 1, 0, 32'h60, 32'h6, 0, 0, 0, 32'h3333, 32'h4444);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_outs($sformatf("to_wait%0d", k), 2'b01, 1, 0, 32'h60, 32'h6, 0, 0, 0, 32'h3333, 32'h4444);
    end
    tick();
    check_outs("to_abort", 2'b01, 0, 0, 32'h60, 32'h6, 1, 0, 1, 32'h0, 32'h4444);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("to_idle", 2'b00, 0, 0, 32'h60, 32'h6, 0, 0, 0, 32'h0, 32'h4444);

    // Same again but memory answers on the 8th BUSY edge: no error
    drive(1, 0, 32'h64, 32'h7, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("tr_grant", 2'b01, 1, 0, 32'h64, 32'h7, 0, 0, 0, 32'h0, 32'h4444);
    repeat (7) tick();
    check_outs("tr_wait7", 2'b01, 1, 0, 32'h64, 32'h7, 0, 0, 0, 32'h0, 32'h4444);
    iMemRdy = 1'b1; iMemData = 32'h8888;
    tick();
    check_outs("tr_done", 2'b01, 0, 0, 32'h64, 32'h7, 1, 0, 0, 32'h8888, 32'h4444);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("tr_idle", 2'b00, 0, 0, 32'h64, 32'h7, 0, 0, 0, 32'h8888, 32'h4444);

    // Reset mid-BUSY: M1 transaction dropped without rdy, M0 wins first tie afterwards
    drive(0, 0, 0, 0, 1, 0, 32'h70, 32'h7070, 0, 0);
    tick();
    check_outs("rb_grant", 2'b10, 1, 0, 32'h70, 32'h7070, 0, 0, 0, 32'h8888, 32'h4444);
    tick();
    #2;
    iRst = 1'b1;
    #1;
    check_outs("rb_async", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    iMemRdy = 1'b1; iMemData = 32'h9999;
    tick();
    tick();
    check_outs("rb_held", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    iRst = 1'b0;
    drive(1, 0, 32'h80, 32'h8, 1, 0, 32'h90, 32'h9, 0, 0);
    tick();
    check_outs("rb_first", 2'b01, 1, 0, 32'h80, 32'h8, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
